// File: rtl/stream_block_tiler.sv
// stream_block_tiler
//   Streaming front end for the compressor pipeline. Raster-order pixels are
//   written into two ping-pong strip banks, each holding BLK image rows. A full
//   bank is read back as BLKxBLK tiles, left to right, and strips are emitted
//   top to bottom.
//
//   Build option: define ZIGZAG_EN to emit each tile in JPEG zigzag order from
//   an 8x8 index ROM (BLK must be 8). Without it, tiles are emitted row-major.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   start_img      one-cycle pulse that arms a new frame (ignored while busy)
//   in_valid       raster pixel valid
//   in_ready       tiler accepts in_pix this cycle
//   in_pix         signed raster pixel
//   out_valid      tiled pixel valid
//   out_ready      downstream accepts out_pix
//   out_pix        signed tiled pixel
//   out_blk_first  out_pix is sample 0 of a tile
//   out_img_last   out_pix is the final sample of the frame
//   busy           frame in progress
//   img_done       one-cycle pulse after the frame's last sample is handed off
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its data and flags stable until that
// edge; ready may change freely.
module stream_block_tiler #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int BLK   = 8,
    parameter int PIX_W = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_img,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [PIX_W-1:0] in_pix,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [PIX_W-1:0] out_pix,
    output logic                    out_blk_first,
    output logic                    out_img_last,
    output logic                    busy,
    output logic                    img_done
);
    localparam int DEPTH = BLK * IMG_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int NT    = IMG_W / BLK;
    localparam int NS    = IMG_H / BLK;
    localparam int TW    = (NT > 1) ? $clog2(NT) : 1;
    localparam int SW    = (NS > 1) ? $clog2(NS) : 1;
    localparam int LB    = $clog2(BLK);
    localparam int KW    = 2 * LB;

    generate
        if ((IMG_W % BLK) != 0 || (IMG_H % BLK) != 0 || BLK < 2 || (BLK & (BLK - 1)) != 0) begin : g_bad_geom
            $error("stream_block_tiler: IMG_W/IMG_H must be multiples of BLK and BLK a power of two");
        end
`ifdef ZIGZAG_EN
        if (BLK != 8) begin : g_bad_zigzag
            $error("stream_block_tiler: ZIGZAG_EN requires BLK == 8");
        end
`endif
    endgenerate

    typedef enum logic {W_IDLE, W_FILL}  w_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [1:0]    full;
    logic          wr_bank, iss_bank, drain_bank;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] wr_strip, iss_strip;
    logic [TW-1:0] iss_tile;
    logic [KW-1:0] iss_k;

    // Read pipeline: stage 1 is the registered memory output, stage 2 the
    // output register. Both advance together whenever the output is free.
    logic                    s1_valid, s1_first, s1_slast, s1_ilast, out_slast;
    logic signed [PIX_W-1:0] s1_pix;
    logic [PIX_W-1:0]        mem [2][DEPTH];

    logic          wr_fire, wr_strip_end, out_fire, drain_end, adv, issue;
    logic          iss_blk_first, iss_strip_last, iss_img_last;
    logic [LB-1:0] rr, cc;
    logic [AW-1:0] rd_addr;

    assign in_ready     = (w_state == W_FILL) && !full[wr_bank];
    assign wr_fire      = in_valid && in_ready;
    assign wr_strip_end = wr_fire && (wr_addr == AW'(DEPTH - 1));
    assign out_fire     = out_valid && out_ready;
    assign drain_end    = out_fire && out_slast && (r_state == R_DRAIN);

    // Reads are issued as soon as the issue bank is full; the issue pointer
    // moves to the other bank while the tail of this one is still in flight,
    // which keeps strip boundaries bubble-free.
    assign adv   = !out_valid || out_ready;
    assign issue = adv && full[iss_bank];

`ifdef ZIGZAG_EN
    // JPEG zigzag: entry k is the raster index (row*8 + col) inside the tile.
    localparam logic [5:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
    assign {rr, cc} = ZZ[iss_k];
`else
    assign rr = iss_k[KW-1:LB];
    assign cc = iss_k[LB-1:0];
`endif

    assign rd_addr        = AW'(int'(rr) * IMG_W + int'(iss_tile) * BLK + int'(cc));
    assign iss_blk_first  = (iss_k == '0);
    assign iss_strip_last = (iss_k == '1) && (iss_tile == TW'(NT - 1));
    assign iss_img_last   = iss_strip_last && (iss_strip == SW'(NS - 1));

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (start_img && !busy) w_next = W_FILL;
            W_FILL:  if (wr_strip_end && wr_strip == SW'(NS - 1)) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (full[drain_bank]) r_next = R_DRAIN;
            R_DRAIN: if (drain_end) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Strip storage has no reset: contents are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_bank][wr_addr] <= in_pix;
        if (issue)   s1_pix <= mem[iss_bank][rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            r_state       <= R_IDLE;
            busy          <= 1'b0;
            img_done      <= 1'b0;
            full          <= '0;
            wr_bank       <= 1'b0;
            iss_bank      <= 1'b0;
            drain_bank    <= 1'b0;
            wr_addr       <= '0;
            wr_strip      <= '0;
            iss_strip     <= '0;
            iss_tile      <= '0;
            iss_k         <= '0;
            s1_valid      <= 1'b0;
            s1_first      <= 1'b0;
            s1_slast      <= 1'b0;
            s1_ilast      <= 1'b0;
            out_valid     <= 1'b0;
            out_pix       <= '0;
            out_blk_first <= 1'b0;
            out_img_last  <= 1'b0;
            out_slast     <= 1'b0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            img_done <= out_fire && out_img_last;
            if (start_img && !busy)           busy <= 1'b1;
            else if (out_fire && out_img_last) busy <= 1'b0;

            if (wr_fire) wr_addr <= wr_strip_end ? '0 : wr_addr + 1'b1;
            if (wr_strip_end) begin
                full[wr_bank] <= 1'b1;
                wr_bank       <= ~wr_bank;
                wr_strip      <= (wr_strip == SW'(NS - 1)) ? '0 : wr_strip + 1'b1;
            end
            // The writer can never be filling the bank being drained, so the
            // set above and this clear always touch different flags.
            if (drain_end) begin
                full[drain_bank] <= 1'b0;
                drain_bank       <= ~drain_bank;
            end

            if (issue) begin
                iss_k <= iss_k + 1'b1;
                if (iss_k == '1) begin
                    if (iss_tile == TW'(NT - 1)) begin
                        iss_tile  <= '0;
                        iss_bank  <= ~iss_bank;
                        iss_strip <= (iss_strip == SW'(NS - 1)) ? '0 : iss_strip + 1'b1;
                    end else begin
                        iss_tile <= iss_tile + 1'b1;
                    end
                end
            end

            if (adv) begin
                s1_valid      <= issue;
                s1_first      <= issue && iss_blk_first;
                s1_slast      <= issue && iss_strip_last;
                s1_ilast      <= issue && iss_img_last;
                out_valid     <= s1_valid;
                if (s1_valid) out_pix <= s1_pix;
                out_blk_first <= s1_valid && s1_first;
                out_img_last  <= s1_valid && s1_ilast;
                out_slast     <= s1_valid && s1_slast;
            end
        end
    end
endmodule
